// File: rtl/lcd_pkg.sv
// Shared types and tables for the HD44780 4-bit controller: FSM states, the
// fixed power-up nibble ROM and the configuration byte list.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_NIB,
    INIT_WAIT,
    IDLE,
    HI,
    GAP,
    LO,
    POST
  } lcd_state_e;

  typedef enum logic [1:0] {
    N_IDLE,
    N_SETUP,
    N_EN
  } nib_state_e;

  typedef enum logic [1:0] {
    W_INIT1,
    W_INIT2,
    W_CMD
  } init_wait_e;

  typedef struct packed {
    logic [3:0] nib;
    init_wait_e wsel;
  } init_step_t;

  localparam logic [1:0] LAST_STEP   = 2'd3;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_FUNCSET = 8'h28;

  // Three 0x3 wake-up nibbles force 8-bit mode regardless of prior state, then 0x2 switches to 4-bit.
  function automatic init_step_t init_rom(input logic [1:0] idx);
    init_step_t s;
    case (idx)
      2'd0:    s = '{nib: 4'h3, wsel: W_INIT1};
      2'd1:    s = '{nib: 4'h3, wsel: W_INIT2};
      2'd2:    s = '{nib: 4'h3, wsel: W_CMD};
      default: s = '{nib: 4'h2, wsel: W_CMD};
    endcase
    return s;
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx,
                                          input logic [7:0] entry,
                                          input logic [7:0] dispctl);
    logic [7:0] b;
    case (idx)
      2'd0:    b = CMD_FUNCSET;
      2'd1:    b = entry;
      2'd2:    b = dispctl;
      default: b = CMD_CLEAR;
    endcase
    return b;
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one nibble onto the LCD pins: T_SETUP cycles of setup, then lcd_e high for T_EN cycles.
// start_i is only honoured when idle; done_o marks the final e-high cycle.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] nib_i,
  input  logic       rs_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] lcd_data_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o
);

  localparam int unsigned TMAX = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int TW = $clog2(TMAX + 1);

  if (T_SETUP < 1) begin : g_chk_setup
    $error("lcd_nibble_tx: T_SETUP must be at least 1");
  end
  if (T_EN < 1) begin : g_chk_en
    $error("lcd_nibble_tx: T_EN must be at least 1");
  end

  nib_state_e    state_q;
  logic [TW-1:0] cnt_q;
  logic [3:0]    data_q;
  logic          rs_q;
  logic          e_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= N_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      case (state_q)
        N_IDLE: begin
          if (start_i) begin
            data_q  <= nib_i;
            rs_q    <= rs_i;
            cnt_q   <= TW'(T_SETUP - 1);
            state_q <= N_SETUP;
          end
        end
        N_SETUP: begin
          if (cnt_q == '0) begin
            e_q     <= 1'b1;
            cnt_q   <= TW'(T_EN - 1);
            state_q <= N_EN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        N_EN: begin
          if (cnt_q == '0) begin
            e_q     <= 1'b0;
            state_q <= N_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= N_IDLE;
      endcase
    end
  end

  // Data and rs only reload on a new start, so they hold past the e fall until the caller relaunches.
  assign busy_o     = (state_q != N_IDLE);
  assign done_o     = (state_q == N_EN) && (cnt_q == '0);
  assign lcd_data_o = data_q;
  assign lcd_e_o    = e_q;
  assign lcd_rs_o   = rs_q;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit write-only controller: autonomous power-up/config, then one byte per IDLE visit.
// A byte is taken on wr_valid && wr_ready; first lcd_e rise follows T_SETUP cycles later.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter logic [7:0]  ENTRY   = 8'h06,
  parameter logic [7:0]  DISPCTL = 8'h0C,
  parameter int unsigned CNT_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_byte,
  output logic       wr_ready,
  output logic       init_done,
  output logic [3:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       sf_ce0
);

  localparam int unsigned T_MAX_A = (T_PWRUP > T_INIT1) ? T_PWRUP : T_INIT1;
  localparam int unsigned T_MAX_B = (T_CLR > T_INIT2) ? T_CLR : T_INIT2;
  localparam int unsigned T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned T_MAX   = (T_MAX_C > T_CMD) ? T_MAX_C : T_CMD;

  if (T_PWRUP < 1 || T_INIT1 < 1 || T_INIT2 < 1 || T_CMD < 1 || T_CLR < 1) begin : g_chk_zero
    $error("lcd_hd44780_ctrl: all T_* delays must be at least 1");
  end
  if (T_NIB <= T_SETUP) begin : g_chk_nib
    $error("lcd_hd44780_ctrl: T_NIB must exceed T_SETUP");
  end
  if (T_MAX > (1 << CNT_W)) begin : g_chk_width
    $error("lcd_hd44780_ctrl: CNT_W too narrow for the longest delay");
  end

  function automatic logic [CNT_W-1:0] ld(input int unsigned t);
    return CNT_W'(t - 1);
  endfunction

  function automatic logic [CNT_W-1:0] wait_ld(input init_wait_e w);
    logic [CNT_W-1:0] v;
    case (w)
      W_INIT1: v = ld(T_INIT1);
      W_INIT2: v = ld(T_INIT2);
      default: v = ld(T_CMD);
    endcase
    return v;
  endfunction

  lcd_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pwr_armed_q;
  logic [1:0]       step_q;
  logic             cfg_q;
  logic [7:0]       byte_q;
  logic             rs_q;
  logic             ready_q;
  logic             done_q;

  logic       nib_start;
  logic [3:0] nib_val;
  logic       nib_rs;
  logic       nib_busy;
  logic       nib_done;
  logic       cnt_zero;
  logic       accept;

  assign cnt_zero = (cnt_q == '0);
  assign accept   = (state_q == IDLE) && ready_q && wr_valid && !nib_busy;

  // Nibble launches coincide with the FSM edge that enters HI/LO/INIT_NIB, keeping setup at exactly T_SETUP.
  always_comb begin
    nib_start = 1'b0;
    nib_val   = 4'h0;
    nib_rs    = 1'b0;
    case (state_q)
      PWR_WAIT: begin
        nib_start = pwr_armed_q && cnt_zero;
        nib_val   = init_rom(2'd0).nib;
      end
      INIT_WAIT: begin
        nib_start = cnt_zero;
        if (step_q == LAST_STEP) begin
          nib_val = cfg_byte(2'd0, ENTRY, DISPCTL)[7:4];
        end else begin
          nib_val = init_rom(step_q + 2'd1).nib;
        end
      end
      IDLE: begin
        nib_start = accept;
        nib_val   = wr_byte[7:4];
        nib_rs    = wr_rs;
      end
      GAP: begin
        nib_start = cnt_zero;
        nib_val   = byte_q[3:0];
        nib_rs    = rs_q;
      end
      POST: begin
        nib_start = cnt_zero && cfg_q && (step_q != LAST_STEP);
        nib_val   = cfg_byte(step_q + 2'd1, ENTRY, DISPCTL)[7:4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      pwr_armed_q <= 1'b0;
      step_q      <= 2'd0;
      cfg_q       <= 1'b0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        PWR_WAIT: begin
          if (!pwr_armed_q) begin
            pwr_armed_q <= 1'b1;
            cnt_q       <= ld(T_PWRUP);
          end else if (cnt_zero) begin
            step_q  <= 2'd0;
            state_q <= INIT_NIB;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        INIT_NIB: begin
          if (nib_done) begin
            cnt_q   <= wait_ld(init_rom(step_q).wsel);
            state_q <= INIT_WAIT;
          end
        end
        INIT_WAIT: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (step_q == LAST_STEP) begin
            step_q  <= 2'd0;
            cfg_q   <= 1'b1;
            byte_q  <= cfg_byte(2'd0, ENTRY, DISPCTL);
            rs_q    <= 1'b0;
            state_q <= HI;
          end else begin
            step_q  <= step_q + 2'd1;
            state_q <= INIT_NIB;
          end
        end
        IDLE: begin
          if (accept) begin
            byte_q  <= wr_byte;
            rs_q    <= wr_rs;
            ready_q <= 1'b0;
            state_q <= HI;
          end
        end
        HI: begin
          if (nib_done) begin
            cnt_q   <= ld(T_NIB - T_SETUP);
            state_q <= GAP;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            state_q <= LO;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LO: begin
          if (nib_done) begin
            cnt_q   <= is_long_cmd(rs_q, byte_q) ? ld(T_CLR) : ld(T_CMD);
            state_q <= POST;
          end
        end
        POST: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (cfg_q && (step_q != LAST_STEP)) begin
            step_q  <= step_q + 2'd1;
            byte_q  <= cfg_byte(step_q + 2'd1, ENTRY, DISPCTL);
            rs_q    <= 1'b0;
            state_q <= HI;
          end else begin
            cfg_q   <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= PWR_WAIT;
      endcase
    end
  end

  lcd_nibble_tx #(
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN)
  ) u_nib (
    .clk        (clk),
    .rst        (rst),
    .start_i    (nib_start),
    .nib_i      (nib_val),
    .rs_i       (nib_rs),
    .busy_o     (nib_busy),
    .done_o     (nib_done),
    .lcd_data_o (lcd_data),
    .lcd_e_o    (lcd_e),
    .lcd_rs_o   (lcd_rs)
  );

  assign wr_ready  = ready_q;
  assign init_done = done_q;
  assign lcd_rw    = 1'b0;
  assign sf_ce0    = 1'b1;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl with shortened delays; nibble monitor checks against a queue of expectations.
module tb_lcd_hd44780_ctrl;

  localparam int T_PWRUP = 100;
  localparam int T_INIT1 = 40;
  localparam int T_INIT2 = 20;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 12;
  localparam int T_NIB   = 5;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_byte;
  logic       wr_ready;
  logic       init_done;
  logic [3:0] lcd_data;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       sf_ce0;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .T_PWRUP (T_PWRUP),
    .T_INIT1 (T_INIT1),
    .T_INIT2 (T_INIT2),
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_NIB   (T_NIB),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR),
    .ENTRY   (8'h06),
    .DISPCTL (8'h0C),
    .CNT_W   (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_rs     (wr_rs),
    .wr_byte   (wr_byte),
    .wr_ready  (wr_ready),
    .init_done (init_done),
    .lcd_data  (lcd_data),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .sf_ce0    (sf_ce0)
  );

  // gap: e-low cycles before this pulse (-1 = unchecked); post: fall-to-wr_ready cycles (-1 = unchecked)
  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         gap;
    int         post;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] b;
    int         post;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] n, input int gap, input int post);
    exp_t e;
    e.rs = rs; e.nib = n; e.gap = gap; e.post = post;
    exp_q.push_back(e);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b, input int hi_gap, input int post);
    push_nib(rs, b[7:4], hi_gap, -1);
    push_nib(rs, b[3:0], T_NIB, post);
  endtask

  task automatic push_init();
    push_nib(1'b0, 4'h3, -1, -1);
    push_nib(1'b0, 4'h3, T_INIT1 + T_SETUP, -1);
    push_nib(1'b0, 4'h3, T_INIT2 + T_SETUP, -1);
    push_nib(1'b0, 4'h2, T_CMD + T_SETUP, -1);
    push_byte(1'b0, 8'h28, T_CMD + T_SETUP, -1);
    push_byte(1'b0, 8'h06, T_CMD + T_SETUP, -1);
    push_byte(1'b0, 8'h0C, T_CMD + T_SETUP, -1);
    push_byte(1'b0, 8'h01, T_CMD + T_SETUP, T_CLR);
  endtask

  // Monitor: samples on the falling clock edge, records each lcd_e pulse and scores it.
  int   cyc = 0;
  int   hi_cnt = 0;
  int   last_fall = -1;
  int   cur_gap = -1;
  int   pending_post = -1;
  bit   prev_e = 1'b0;
  bit   prev_rdy = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_e = 1'b0; prev_rdy = 1'b0; hi_cnt = 0;
      last_fall = -1; cur_gap = -1; pending_post = -1;
    end else begin
      if (lcd_e && !prev_e) begin
        cur_gap = (last_fall >= 0) ? cyc - last_fall : -1;
        hi_cnt  = 0;
      end
      if (lcd_e) hi_cnt++;
      if (!lcd_e && prev_e) begin
        last_fall = cyc;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_nibble: got data=%h rs=%0d, expected none", lcd_data, lcd_rs);
        end else begin
          m_e = exp_q.pop_front();
          check("nib_data", int'(lcd_data), int'(m_e.nib));
          check("nib_rs", int'(lcd_rs), int'(m_e.rs));
          check("e_width", hi_cnt, T_EN);
          if (m_e.gap >= 0) check("e_gap", cur_gap, m_e.gap);
          pending_post = m_e.post;
        end
      end
      if (wr_ready && !prev_rdy && pending_post >= 0) begin
        check("post_wait", cyc - last_fall, pending_post);
        pending_post = -1;
      end
      prev_e   = lcd_e;
      prev_rdy = wr_ready;
    end
  end

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!wr_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) begin
      compared++;
      mismatched++;
      $display("FAIL %s: wr_ready not seen within %0d cycles, expected high", name, budget);
    end
  endtask

  // Called on a falling edge; returns on a falling edge after the byte has been accepted.
  task automatic send(input logic rs, input logic [7:0] b, input int post, input bit hold);
    push_byte(rs, b, -1, post);
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_byte  = b;
    wait_ready("send_ready", 2000);
    if (wr_ready) begin
      @(posedge clk);
      #1;
      if (!hold) begin
        wr_valid = 1'b0;
        wr_rs    = ~rs;
        wr_byte  = ~b;
      end
      @(negedge clk);
    end else begin
      wr_valid = 1'b0;
    end
  endtask

  task automatic check_pwrup_quiet();
    int e_hits = 0;
    repeat (T_PWRUP) begin
      @(negedge clk);
      if (lcd_e) e_hits++;
    end
    check("pwrup_e_low", e_hits, 0);
  endtask

  initial begin
    bit p_e;
    int rises;
    int n;

    vecs[0] = '{rs: 1'b1, b: 8'h49, post: T_CMD};
    vecs[1] = '{rs: 1'b0, b: 8'h01, post: T_CLR};
    vecs[2] = '{rs: 1'b1, b: 8'h01, post: T_CMD};
    vecs[3] = '{rs: 1'b0, b: 8'h02, post: T_CLR};
    vecs[4] = '{rs: 1'b0, b: 8'h80, post: T_CMD};
    vecs[5] = '{rs: 1'b1, b: 8'hA5, post: T_CMD};

    rst = 1'b0; wr_valid = 1'b0; wr_rs = 1'b0; wr_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_lcd_e", int'(lcd_e), 0);
    check("rst_lcd_rs", int'(lcd_rs), 0);
    check("rst_lcd_data", int'(lcd_data), 0);
    check("rst_lcd_rw", int'(lcd_rw), 0);
    check("rst_sf_ce0", int'(sf_ce0), 1);
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_init_done", int'(init_done), 0);

    // Request held from before init: must wait for the first ready cycle.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_byte = 8'h41;
    rst = 1'b1;
    push_init();
    push_byte(1'b1, 8'h41, -1, T_CMD);
    check_pwrup_quiet();
    wait_ready("init_ready", 3000);
    check("init_done_at_ready", int'(init_done), 1);
    check("init_nibbles_consumed", exp_q.size(), 2);
    @(posedge clk);
    #1;
    wr_valid = 1'b0; wr_byte = 8'hFF; wr_rs = 1'b0;
    @(negedge clk);
    check("ready_drop_after_accept", int'(wr_ready), 0);

    foreach (vecs[i]) send(vecs[i].rs, vecs[i].b, vecs[i].post, 1'b0);
    wait_ready("table_drain", 500);
    check("table_drained", exp_q.size(), 0);

    // Back-to-back with wr_valid held and the byte changing after each acceptance.
    send(1'b1, 8'hA1, T_CMD, 1'b1);
    send(1'b1, 8'hB2, T_CMD, 1'b1);
    send(1'b1, 8'hC3, T_CMD, 1'b0);
    wait_ready("b2b_drain", 500);
    check("b2b_drained", exp_q.size(), 0);
    check("init_done_sticky", int'(init_done), 1);

    // Reset during the low-nibble e-high phase.
    push_nib(1'b1, 4'h5, -1, -1);
    wr_valid = 1'b1; wr_rs = 1'b1; wr_byte = 8'h55;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    p_e = 1'b0; rises = 0; n = 0;
    while (rises < 2 && n < 200) begin
      @(negedge clk);
      if (lcd_e && !p_e) rises++;
      p_e = lcd_e;
      n++;
    end
    check("lo_pulse_reached", rises, 2);
    #1 rst = 1'b0;
    #1;
    check("midrst_lcd_e", int'(lcd_e), 0);
    check("midrst_lcd_data", int'(lcd_data), 0);
    check("midrst_wr_ready", int'(wr_ready), 0);
    check("midrst_init_done", int'(init_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_init();
    check_pwrup_quiet();
    wait_ready("reinit_ready", 3000);
    check("reinit_done", int'(init_done), 1);
    check("reinit_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
